// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encoding, FSM
// state encoding and the default data RAM capacity.
package lsu_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 499;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    // Number of bytes touched by an access; the illegal size is rejected
    // separately, so its value here only has to be harmless.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the low byte/half/word of a little-endian RAM word and
// zero- or sign-extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    // NOTE: every path assigns result first, so no latch can be inferred.
    always_comb begin
        result = word;
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'h0, word[7:0]}
                                            : {{24{word[7]}}, word[7:0]};
            SIZE_HALF: result = is_unsigned ? {16'h0, word[15:0]}
                                            : {{16{word[15]}}, word[15:0]};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a registered
// data RAM: checks alignment/range, issues the access, returns one response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        mem_write_enable,
    output logic        mem_write_byte_enable,
    output logic        mem_write_half_word_enable,
    output logic        mem_read_byte_enable,
    output logic        mem_read_half_word_enable,
    output logic [31:0] mem_data_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    size_e       req_size_e;
    logic [32:0] req_end;
    logic        req_fault;
    logic        accept;
    logic [31:0] ext_data;

    assign req_size_e = size_e'(req_size);

    // End address is computed one bit wider so addresses near 2^32 cannot wrap.
    assign req_end = {1'b0, req_addr} + 33'(size_bytes(req_size_e));

    always_comb begin
        req_fault = 1'b0;
        case (req_size_e)
            SIZE_ILLEGAL: req_fault = 1'b1;
            SIZE_HALF:    req_fault = req_addr[0];
            SIZE_WORD:    req_fault = (req_addr[1:0] != 2'b00);
            default:      req_fault = 1'b0;
        endcase
        if (req_end > 33'(MEM_BYTES)) begin
            req_fault = 1'b1;
        end
    end

    load_extend u_load_extend (
        .word        (mem_read_data),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size_e;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    fault_d = req_fault;
                    rdata_d = '0;
                    state_d = req_fault ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = we_q ? ST_RESP : ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = ext_data;
                state_d = ST_RESP;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Write strobes decode straight from state, so reset drops them at once.
    assign mem_write_enable           = (state_q == ST_ISSUE) && we_q;
    assign mem_write_byte_enable      = mem_write_enable && (size_q == SIZE_BYTE);
    assign mem_write_half_word_enable = mem_write_enable && (size_q == SIZE_HALF);
    assign mem_read_byte_enable       = 1'b0;
    assign mem_read_half_word_enable  = 1'b0;
    assign mem_data_address           = addr_q;
    assign mem_write_data             = wdata_q;

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = rd_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array model of the
// registered data RAM.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic        mem_write_enable;
    logic        mem_write_byte_enable;
    logic        mem_write_half_word_enable;
    logic        mem_read_byte_enable;
    logic        mem_read_half_word_enable;
    logic [31:0] mem_data_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr_sub_cnt = 0;
    int rd_sub_cnt = 0;

    logic [7:0] ram [0:511];

    load_store_unit #(.MEM_BYTES(499)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_we                     (req_we),
        .req_size                   (req_size),
        .req_unsigned               (req_unsigned),
        .req_addr                   (req_addr),
        .req_wdata                  (req_wdata),
        .req_rd                     (req_rd),
        .resp_valid                 (resp_valid),
        .resp_rdata                 (resp_rdata),
        .resp_rd                    (resp_rd),
        .resp_fault                 (resp_fault),
        .mem_write_enable           (mem_write_enable),
        .mem_write_byte_enable      (mem_write_byte_enable),
        .mem_write_half_word_enable (mem_write_half_word_enable),
        .mem_read_byte_enable       (mem_read_byte_enable),
        .mem_read_half_word_enable  (mem_read_half_word_enable),
        .mem_data_address           (mem_data_address),
        .mem_write_data             (mem_write_data),
        .mem_read_data              (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM: full word read every cycle, writes per strobe.
    always @(posedge clk) begin
        logic [8:0] a;
        a = mem_data_address[8:0];
        mem_read_data <= {ram[a + 9'd3], ram[a + 9'd2], ram[a + 9'd1], ram[a]};
        if (mem_write_enable) begin
            wr_cnt = wr_cnt + 1;
            ram[a] = mem_write_data[7:0];
            if (!mem_write_byte_enable) begin
                ram[a + 9'd1] = mem_write_data[15:8];
                if (!mem_write_half_word_enable) begin
                    ram[a + 9'd2] = mem_write_data[23:16];
                    ram[a + 9'd3] = mem_write_data[31:24];
                end
            end
        end
        if (mem_write_byte_enable || mem_write_half_word_enable) wr_sub_cnt = wr_sub_cnt + 1;
        if (mem_read_byte_enable || mem_read_half_word_enable) rd_sub_cnt = rd_sub_cnt + 1;
    end

    // Issues one request and waits (bounded) for its response; lat = 0 on timeout.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          output int lat, output logic [31:0] rdata, output logic fault,
                          output logic [4:0] rtag, output logic valid_after);
        lat = 0;
        rdata = '0;
        fault = 1'b0;
        rtag = '0;
        valid_after = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        req_rd = rd;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                rdata = resp_rdata;
                fault = resp_fault;
                rtag = resp_rd;
                break;
            end
        end
        @(negedge clk);
        valid_after = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        n_checks++;
        if ({resp_valid, resp_fault, mem_write_enable, mem_data_address, resp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b fault=%b we=%b addr=%h rdata=%h expected all 0",
                     resp_valid, resp_fault, mem_write_enable, mem_data_address, resp_rdata);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_loads();
        int lat;
        logic [31:0] d;
        logic f, va;
        logic [4:0] t;
        ram[9'h10] = 8'h80; ram[9'h11] = 8'h12; ram[9'h12] = 8'h34; ram[9'h13] = 8'h56;
        ram[9'h20] = 8'h34; ram[9'h21] = 8'hF2; ram[9'h22] = 8'h00; ram[9'h23] = 8'h00;
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 5'd7, lat, d, f, t, va);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", lat); end
        n_checks++;
        if (d !== 32'hFFFFFF80 || f !== 1'b0 || t !== 5'd7) begin
            n_fail++; $display("FAIL lb_data: got %h fault %b rd %0d expected ffffff80 fault 0 rd 7", d, f, t);
        end
        n_checks++;
        if (va !== 1'b0) begin n_fail++; $display("FAIL lb_single_pulse: got resp_valid %b expected 0", va); end
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 5'd1, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", d); end
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 5'd2, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'h0000F234 || lat !== 3) begin n_fail++; $display("FAIL lhu_data: got %h lat %0d expected 0000f234 lat 3", d, lat); end
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 5'd3, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'hFFFFF234) begin n_fail++; $display("FAIL lh_data: got %h expected fffff234", d); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd4, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'h56341280) begin n_fail++; $display("FAIL lw_data: got %h expected 56341280", d); end
        n_checks++;
        if (rd_sub_cnt !== 0) begin n_fail++; $display("FAIL load_read_enables: got %0d cycles expected 0", rd_sub_cnt); end
    endtask

    task automatic test_stores();
        int lat, w0, s0;
        logic [31:0] d;
        logic f, va;
        logic [4:0] t;
        for (int i = 'h40; i < 'h4C; i++) ram[i] = 8'h00;
        w0 = wr_cnt;
        s0 = wr_sub_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 5'd9, lat, d, f, t, va);
        n_checks++;
        if (lat !== 2 || d !== 32'h0 || f !== 1'b0 || t !== 5'd9) begin
            n_fail++; $display("FAIL sw_resp: got lat %0d rdata %h fault %b rd %0d expected 2 0 0 9", lat, d, f, t);
        end
        n_checks++;
        if (wr_cnt - w0 !== 1 || wr_sub_cnt - s0 !== 0) begin
            n_fail++; $display("FAIL sw_strobes: got we %0d sub %0d cycles expected 1 0", wr_cnt - w0, wr_sub_cnt - s0);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd10, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_readback: got %h expected deadbeef", d); end
        do_req(1'b1, 2'b00, 1'b0, 32'h44, 32'h123456AB, 5'd11, lat, d, f, t, va);
        do_req(1'b0, 2'b10, 1'b1, 32'h44, 32'h0, 5'd12, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'h000000AB) begin n_fail++; $display("FAIL sb_readback: got %h expected 000000ab", d); end
        do_req(1'b1, 2'b01, 1'b0, 32'h48, 32'hCAFE1234, 5'd13, lat, d, f, t, va);
        do_req(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 5'd14, lat, d, f, t, va);
        n_checks++;
        if (d !== 32'h00001234) begin n_fail++; $display("FAIL sh_readback: got %h expected 00001234", d); end
    endtask

    task automatic test_faults();
        int lat, w0;
        logic [31:0] d;
        logic f, va;
        logic [4:0] t;
        logic        vwe   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  vsize [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] vaddr [5] = '{32'h42, 32'h21, 32'd496, 32'h0, 32'hFFFF_FFFF};
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            do_req(vwe[i], vsize[i], 1'b0, vaddr[i], 32'h5555AAAA, 5'(i + 16), lat, d, f, t, va);
            n_checks++;
            if (lat !== 1 || f !== 1'b1 || d !== 32'h0 || t !== 5'(i + 16)) begin
                n_fail++;
                $display("FAIL fault_%0d: got lat %0d fault %b rdata %h rd %0d expected 1 1 0 %0d", i, lat, f, d, t, i + 16);
            end
        end
        n_checks++;
        if (wr_cnt !== w0) begin n_fail++; $display("FAIL fault_no_write: got %0d writes expected 0", wr_cnt - w0); end
        ram[9'd498] = 8'hC3;
        do_req(1'b0, 2'b00, 1'b1, 32'd498, 32'h0, 5'd21, lat, d, f, t, va);
        n_checks++;
        if (lat !== 3 || f !== 1'b0 || d !== 32'h000000C3) begin
            n_fail++; $display("FAIL last_byte_ok: got lat %0d fault %b rdata %h expected 3 0 000000c3", lat, f, d);
        end
    endtask

    task automatic test_reset_mid_store();
        int seen;
        ram[9'h50] = 8'h77;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h11223344; req_rd = 5'd25;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++;
        if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL abort_issue_we: got %b expected 1", mem_write_enable); end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_we_drop: got we %b valid %b expected 0 0", mem_write_enable, resp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ram[9'h50] !== 8'h77) begin n_fail++; $display("FAIL abort_ram: got %h expected 77", ram[9'h50]); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d responses expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, ready_cycle;
        logic [4:0] t1, t2;
        logic [31:0] d1, d2;
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
        ram[4] = 8'hA1; ram[5] = 8'hB2; ram[6] = 8'hC3; ram[7] = 8'hD4;
        c1 = 0; c2 = 0; ready_cycle = 0; t1 = '0; t2 = '0; d1 = '0; d2 = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd3;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin req_addr = 32'h4; req_rd = 5'd4; end
            if (k == 5) req_valid = 1'b0;
            if (req_ready && ready_cycle == 0 && k < 5) ready_cycle = k;
            if (resp_valid && c1 == 0) begin c1 = k; t1 = resp_rd; d1 = resp_rdata; end
            else if (resp_valid && c2 == 0) begin c2 = k; t2 = resp_rd; d2 = resp_rdata; end
        end
        n_checks++;
        if (c1 !== 3 || t1 !== 5'd3 || d1 !== 32'h04030201) begin
            n_fail++; $display("FAIL b2b_first: got cycle %0d rd %0d data %h expected 3 3 04030201", c1, t1, d1);
        end
        n_checks++;
        if (ready_cycle !== 4) begin n_fail++; $display("FAIL b2b_ready: got cycle %0d expected 4", ready_cycle); end
        n_checks++;
        if (c2 !== 7 || t2 !== 5'd4 || d2 !== 32'hD4C3B2A1) begin
            n_fail++; $display("FAIL b2b_second: got cycle %0d rd %0d data %h expected 7 4 d4c3b2a1", c2, t2, d2);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        mem_read_data = '0;
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid_store();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 499: byte capacity of the attached data RAM; accesses reaching beyond it fault.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port req_rd  input  5  destination register tag, returned unchanged.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports resp_rdata (output 32, extended load data, 0 for stores/faults), resp_rd (output 5) and resp_fault (output 1).
REQ-014 SHALL have RAM-side ports mem_write_enable, mem_write_byte_enable, mem_write_half_word_enable, mem_read_byte_enable, mem_read_half_word_enable (output 1 each), mem_data_address (output 32), mem_write_data (output 32), mem_read_data (input 32, registered RAM output, little-endian bytes addr..addr+3).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready, registering we, size, unsigned, addr, wdata, rd.
REQ-017 SHALL flag fault at acceptance when: size = 11; size = 01 and addr[0] = 1; size = 10 and addr[1:0] != 0; or addr + bytes(size) > MEM_BYTES (33-bit compare, no wrap).
REQ-018 Faulting request SHALL go IDLE -> RESP with no RAM access; resp_valid one cycle after acceptance edge, resp_fault = 1.
REQ-019 Store SHALL go IDLE -> ISSUE -> RESP; mem_write_enable = 1 for exactly the ISSUE cycle with byte/half enables per size; resp_valid 2 cycles after acceptance.
REQ-020 Load SHALL go IDLE -> ISSUE -> CAPTURE -> RESP; address driven in ISSUE, mem_read_data sampled at end of CAPTURE; resp_valid 3 cycles after acceptance.
REQ-021 Loads SHALL always request a full word (mem_read_byte_enable = mem_read_half_word_enable = 0); extraction done internally: byte = bits 7:0, half = bits 15:0, extended per req_unsigned.
REQ-022 mem_data_address SHALL hold the registered address in all states; mem_write_data SHALL equal registered wdata.
REQ-023 RESP SHALL last one cycle and return to IDLE; no response backpressure.
REQ-024 req_valid while req_ready = 0 SHALL be ignored; requester holds it.

Reset
REQ-025 rst SHALL asynchronously force IDLE and clear all outputs to 0 except req_ready (deasserted during reset, 1 in the first cycle after release).
REQ-026 rst mid-operation SHALL abort the access: no write completes after assertion, no resp_valid for the aborted request.

Structure
REQ-027 SHALL place size encodings, FSM state encoding and MEM_BYTES default in shared package lsu_pkg.
REQ-028 SHALL isolate extraction/extension in combinational sub-module load_extend (inputs word, size, unsigned; output 32-bit result).

Verification
REQ-029 LB addr 0x10, RAM bytes 0x10..0x13 = 80 12 34 56, unsigned 0 -> resp_valid 3 cycles later, resp_rdata 0xFFFFFF80, fault 0.
REQ-030 LHU addr 0x20, bytes = 34 F2 -> resp_rdata 0x0000F234; LH same -> 0xFFFFF234.
REQ-031 SW addr 0x40, wdata 0xDEADBEEF -> mem_write_enable one cycle, byte/half enables 0; subsequent LW 0x40 returns 0xDEADBEEF.
REQ-032 LW addr 0x42, then SH addr 0x21, then LW addr 496 (MEM_BYTES 499) -> each resp_fault 1 one cycle after acceptance, mem_write_enable never asserted.
REQ-033 rst asserted during ISSUE of SW 0x50 -> mem_write_enable drops immediately, RAM 0x50 unchanged, no resp_valid, req_ready 1 after release.
REQ-034 back-to-back req_valid held high for LW 0x0 and LW 0x4 -> second accepted only in IDLE after first RESP; resp_rd tags returned in order.
